renkon_ctrl_actv: RTL and testbench

Parametrised control pipeline for the activation stage of the renkon core.
- Delays the begin/valid/end frame strobes by a configurable latency.
- Generates the datapath output enable at a configurable stage.
- Latches and aligns a per-frame activation mode (relu / bypass / leaky).
- Tracks frame occupancy, beat count and protocol errors for the ninjin-side status logic.

---
 rtl/renkon_ctrl_actv.sv | 126 ++++++++++++
 tb/tb_renkon_ctrl_actv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/renkon_ctrl_actv.sv
// Activation-stage control pipeline: delays frame strobes by LAT cycles, derives the
// datapath enable and frame mode at stage OEPOS, and tracks occupancy, beat count and errors.
module renkon_ctrl_actv #(
  parameter int LAT   = 2,
  parameter int OEPOS = 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            in_begin,
  input  logic            in_valid,
  input  logic            in_end,
  input  logic [1:0]      mode_in,
  output logic            out_begin,
  output logic            out_valid,
  output logic            out_end,
  output logic            actv_oe,
  output logic [1:0]      actv_mode,
  output logic [CNTW-1:0] beat_cnt,
  output logic            busy,
  output logic            err_end
);

  localparam int              OUTW    = $clog2(LAT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [LAT:1]            beg_q, beg_d;
  logic [LAT:1]            vld_q, vld_d;
  logic [LAT:1]            end_q, end_d;
  logic [OEPOS:1][1:0]     mst_q, mst_d;
  logic [1:0]              mode_q, mode_d;
  logic                    open_q, open_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [OUTW-1:0]         outst_q, outst_d;

  // Next-state logic for strobe chains, mode chain, frame tracking and counters.
  always_comb begin
    beg_d   = {beg_q[LAT-1:1], in_begin};
    vld_d   = {vld_q[LAT-1:1], in_valid};
    end_d   = {end_q[LAT-1:1], in_end};
    mst_d   = mst_q;
    mode_d  = mode_q;
    open_d  = open_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    outst_d = outst_q;
    busy_d  = busy_q;

    // A begin updates the frame mode in the same cycle it is sampled.
    if (in_begin) begin
      mode_d = mode_in;
    end else begin
      mode_d = mode_q;
    end
    mst_d[1] = mode_d;
    for (int k = 2; k <= OEPOS; k++) begin
      mst_d[k] = mst_q[k-1];
    end

    if (in_begin) begin
      open_d = ~in_end;
    end else if (in_end) begin
      open_d = 1'b0;
    end else begin
      open_d = open_q;
    end

    err_d = err_q | (in_end & ~open_q & ~in_begin);

    if (in_begin) begin
      cnt_d = CNTW'(in_valid);
    end else if (open_q && in_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Ends still travelling down the chain keep the block busy after the frame closes.
    case ({in_end, end_q[LAT]})
      2'b10:   outst_d = outst_q + OUTW'(1);
      2'b01:   outst_d = outst_q - OUTW'(1);
      default: outst_d = outst_q;
    endcase

    busy_d = open_d | (outst_d != {OUTW{1'b0}});
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      beg_q   <= {LAT{1'b0}};
      vld_q   <= {LAT{1'b0}};
      end_q   <= {LAT{1'b0}};
      mst_q   <= '0;
      mode_q  <= 2'b00;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= {CNTW{1'b0}};
      outst_q <= {OUTW{1'b0}};
    end else begin
      beg_q   <= beg_d;
      vld_q   <= vld_d;
      end_q   <= end_d;
      mst_q   <= mst_d;
      mode_q  <= mode_d;
      open_q  <= open_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
    end
  end

  assign out_begin = beg_q[LAT];
  assign out_valid = vld_q[LAT];
  assign out_end   = end_q[LAT];
  assign actv_oe   = vld_q[OEPOS];
  assign actv_mode = mst_q[OEPOS];
  assign beat_cnt  = cnt_q;
  assign busy      = busy_q;
  assign err_end   = err_q;

endmodule

// File: tb/tb_renkon_ctrl_actv.sv
// Directed bench for renkon_ctrl_actv: two configurations share stimulus; delayed strobes
// and stage-OEPOS mode are checked through per-instance scoreboard queues.
module tb_renkon_ctrl_actv;

  logic       clk = 1'b0;
  logic       xrst = 1'b0;
  logic       in_begin = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_end = 1'b0;
  logic [1:0] mode_in = 2'b00;

  logic        a_ob, a_ov, a_oe_end, a_oe, a_busy, a_err;
  logic [1:0]  a_mode;
  logic [2:0]  a_cnt;
  logic        b_ob, b_ov, b_oe_end, b_oe, b_busy, b_err;
  logic [1:0]  b_mode;
  logic [15:0] b_cnt;

  int total = 0;
  int bad = 0;

  logic [2:0] qa_out[$];
  logic [2:0] qa_oe[$];
  logic [2:0] qb_out[$];
  logic [2:0] qb_oe[$];

  always #5 clk = ~clk;

  renkon_ctrl_actv #(.LAT(2), .OEPOS(1), .CNTW(3)) u_a (
    .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .mode_in(mode_in), .out_begin(a_ob), .out_valid(a_ov), .out_end(a_oe_end),
    .actv_oe(a_oe), .actv_mode(a_mode), .beat_cnt(a_cnt), .busy(a_busy), .err_end(a_err)
  );

  renkon_ctrl_actv #(.LAT(5), .OEPOS(3), .CNTW(16)) u_b (
    .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .mode_in(mode_in), .out_begin(b_ob), .out_valid(b_ov), .out_end(b_oe_end),
    .actv_oe(b_oe), .actv_mode(b_mode), .beat_cnt(b_cnt), .busy(b_busy), .err_end(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipelines start empty: LAT-1 / OEPOS-1 zero entries ahead of the first pushed cycle.
  task automatic reset_queues();
    qa_out.delete(); qa_oe.delete(); qb_out.delete(); qb_oe.delete();
    repeat (1) qa_out.push_back(3'b000);
    repeat (4) qb_out.push_back(3'b000);
    repeat (2) qb_oe.push_back(3'b000);
  endtask

  task automatic chk_zero(input string s);
    chk({s, "_a_ob"}, 32'(a_ob), 32'd0);     chk({s, "_a_ov"}, 32'(a_ov), 32'd0);
    chk({s, "_a_oend"}, 32'(a_oe_end), 32'd0); chk({s, "_a_oe"}, 32'(a_oe), 32'd0);
    chk({s, "_a_mode"}, 32'(a_mode), 32'd0);  chk({s, "_a_cnt"}, 32'(a_cnt), 32'd0);
    chk({s, "_a_busy"}, 32'(a_busy), 32'd0);  chk({s, "_a_err"}, 32'(a_err), 32'd0);
    chk({s, "_b_ob"}, 32'(b_ob), 32'd0);     chk({s, "_b_ov"}, 32'(b_ov), 32'd0);
    chk({s, "_b_oend"}, 32'(b_oe_end), 32'd0); chk({s, "_b_oe"}, 32'(b_oe), 32'd0);
    chk({s, "_b_mode"}, 32'(b_mode), 32'd0);  chk({s, "_b_cnt"}, 32'(b_cnt), 32'd0);
    chk({s, "_b_busy"}, 32'(b_busy), 32'd0);  chk({s, "_b_err"}, 32'(b_err), 32'd0);
  endtask

  // One cycle: drive inputs, push expectations, then compare the outputs after the edge.
  // xm is the mode the frame owning this beat is expected to carry.
  task automatic cyc(input logic b, input logic v, input logic e,
                     input logic [1:0] m, input logic [1:0] xm);
    logic [2:0] ea, eo, eb, ep;
    in_begin = b; in_valid = v; in_end = e; mode_in = m;
    qa_out.push_back({b, v, e}); qa_oe.push_back({v, xm});
    qb_out.push_back({b, v, e}); qb_oe.push_back({v, xm});
    @(posedge clk); #1;
    ea = qa_out.pop_front(); eo = qa_oe.pop_front();
    eb = qb_out.pop_front(); ep = qb_oe.pop_front();
    chk("a_out_begin", 32'(a_ob), 32'(ea[2]));
    chk("a_out_valid", 32'(a_ov), 32'(ea[1]));
    chk("a_out_end", 32'(a_oe_end), 32'(ea[0]));
    chk("a_actv_oe", 32'(a_oe), 32'(eo[2]));
    if (eo[2]) chk("a_actv_mode", 32'(a_mode), 32'(eo[1:0]));
    chk("b_out_begin", 32'(b_ob), 32'(eb[2]));
    chk("b_out_valid", 32'(b_ov), 32'(eb[1]));
    chk("b_out_end", 32'(b_oe_end), 32'(eb[0]));
    chk("b_actv_oe", 32'(b_oe), 32'(ep[2]));
    if (ep[2]) chk("b_actv_mode", 32'(b_mode), 32'(ep[1:0]));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic basic_frame(input string s);
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
    chk({s, "_a_busy_t1"}, 32'(a_busy), 32'd1);
    chk({s, "_b_busy_t1"}, 32'(b_busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 2'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 2'd1);
    cyc(1'b0, 1'b1, 1'b1, 2'd1, 2'd1);
    chk({s, "_a_cnt_t4"}, 32'(a_cnt), 32'd4);
    chk({s, "_b_cnt_t4"}, 32'(b_cnt), 32'd4);
    idle(1);
    chk({s, "_a_busy_t5"}, 32'(a_busy), 32'd1);
    idle(1);
    chk({s, "_a_busy_t6"}, 32'(a_busy), 32'd0);
    chk({s, "_b_busy_t6"}, 32'(b_busy), 32'd1);
    idle(3);
    chk({s, "_b_busy_t9"}, 32'(b_busy), 32'd0);
    chk({s, "_a_err"}, 32'(a_err), 32'd0);
    chk({s, "_b_err"}, 32'(b_err), 32'd0);
    chk({s, "_a_cnt_hold"}, 32'(a_cnt), 32'd4);
  endtask

  initial begin
    reset_queues();
    #12;
    chk_zero("rst");
    xrst = 1'b1;
    @(negedge clk);

    // Plain frame, four beats.
    basic_frame("s1");

    // Mode sampled at begin only; later mode_in changes are ignored.
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 2'd2);
    idle(6);
    chk("s2_b_busy_done", 32'(b_busy), 32'd0);

    // Back-to-back: second begin coincides with the first frame's out_end on instance B.
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 2'd1); chk("s3_b_busy", 32'(b_busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 2'd1); chk("s3_b_busy", 32'(b_busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 2'd1, 2'd1); chk("s3_b_busy", 32'(b_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1); chk("s3_b_busy_gap", 32'(b_busy), 32'd1);
    end
    chk("s3_b_out_end_now", 32'(b_oe_end), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 2'd2); chk("s3_b_busy_overlap", 32'(b_busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 2'd2, 2'd2); chk("s3_b_busy", 32'(b_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1); chk("s3_b_busy_tail", 32'(b_busy), 32'd1);
    end
    idle(1);
    chk("s3_b_busy_done", 32'(b_busy), 32'd0);

    // Ten beats: 3-bit counter saturates, 16-bit counter does not. Reserved mode 3 passes through.
    cyc(1'b1, 1'b1, 1'b0, 2'd3, 2'd3);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 2'd3, 2'd3);
    cyc(1'b0, 1'b1, 1'b1, 2'd3, 2'd3);
    chk("s5_a_cnt_sat", 32'(a_cnt), 32'd7);
    chk("s5_b_cnt", 32'(b_cnt), 32'd10);
    idle(6);
    cyc(1'b1, 1'b1, 1'b1, 2'd2, 2'd2);
    chk("s5_a_cnt_single", 32'(a_cnt), 32'd1);
    chk("s5_b_cnt_single", 32'(b_cnt), 32'd1);
    chk("s5_a_err_single", 32'(a_err), 32'd0);
    chk("s5_b_err_single", 32'(b_err), 32'd0);
    chk("s5_b_busy_single", 32'(b_busy), 32'd1);
    idle(6);
    chk("s5_b_busy_done", 32'(b_busy), 32'd0);

    // Orphan end: sticky error, end strobe still travels the pipeline.
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    chk("s4_a_err_set", 32'(a_err), 32'd1);
    chk("s4_b_err_set", 32'(b_err), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("s4_a_cnt", 32'(a_cnt), 32'd2);
    idle(6);
    chk("s4_a_err_sticky", 32'(a_err), 32'd1);
    chk("s4_b_err_sticky", 32'(b_err), 32'd1);

    // Asynchronous reset mid-frame, away from any clock edge.
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 2'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 2'd1);
    #2;
    xrst = 1'b0;
    in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0; mode_in = 2'd0;
    #1;
    chk_zero("arst");
    #1;
    xrst = 1'b1;
    reset_queues();
    @(negedge clk);
    idle(7);
    basic_frame("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
